// File: rtl/rf_wr_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package rf_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    WR_SEL_NONE,
    WR_SEL_WB,
    WR_SEL_LL
  } wrSel_e;

  typedef enum logic {
    LL_BUF_EMPTY,
    LL_BUF_FULL
  } llBufState_e;

  localparam int unsigned XLEN_DEFAULT    = 32;
  localparam int unsigned AGE_MAX_DEFAULT = 4;

endpackage

// File: rtl/rf_wr_arbiter_if.sv
// Writeback, long-latency and register-file port bundle of rf_wr_arbiter.
interface rf_wr_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  logic            wb_valid_i;
  logic [4:0]      wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            wb_stall_o;

  logic            ll_valid_i;
  logic            ll_ready_o;
  logic [4:0]      ll_rd_i;
  logic [XLEN-1:0] ll_data_i;
  logic            ll_pending_o;
  logic [4:0]      ll_pending_rd_o;

  logic            rf_we_o;
  logic [4:0]      rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o;

  modport master (
    output wb_valid_i, wb_rd_i, wb_data_i, ll_valid_i, ll_rd_i, ll_data_i,
    input  wb_stall_o, ll_ready_o, ll_pending_o, ll_pending_rd_o,
           rf_we_o, rf_waddr_o, rf_wdata_o
  );

  modport slave (
    input  wb_valid_i, wb_rd_i, wb_data_i, ll_valid_i, ll_rd_i, ll_data_i,
    output wb_stall_o, ll_ready_o, ll_pending_o, ll_pending_rd_o,
           rf_we_o, rf_waddr_o, rf_wdata_o
  );
endinterface

// File: rtl/rf_wr_arbiter_ll_result_buf.sv
// One-entry buffer for a long-latency result; drains or drops on request.
module ll_result_buf
  import rf_wr_arbiter_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_data,
  input  logic            drain,
  output logic            ready,
  output logic            full,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] data
);

  llBufState_e state;

  // rd/data are cleared on drain so rd doubles as the pending-rd output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LL_BUF_EMPTY;
      ready <= 1'b1;
      rd    <= '0;
      data  <= '0;
    end else begin
      case (state)
        LL_BUF_EMPTY: begin
          if (in_valid) begin
            state <= LL_BUF_FULL;
            ready <= 1'b0;
            rd    <= in_rd;
            data  <= in_data;
          end
        end
        LL_BUF_FULL: begin
          if (drain) begin
            state <= LL_BUF_EMPTY;
            ready <= 1'b1;
            rd    <= '0;
            data  <= '0;
          end
        end
        default: begin
          state <= LL_BUF_EMPTY;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign full = (state == LL_BUF_FULL);

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter between writeback and a long-latency unit.
// Optional feature: RF_ARB_AGING_EN (WB wins conflicts until the buffer ages out).
module rf_wr_arbiter
  import rf_wr_arbiter_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEFAULT,
  parameter int unsigned AGE_MAX = AGE_MAX_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  rf_wr_arbiter_if.slave     bus
);

  if (AGE_MAX < 1 || AGE_MAX > 15) begin : g_age_range
    $error("AGE_MAX out of range 1..15");
  end

  logic            buf_ready;
  logic            buf_full;
  logic [4:0]      buf_rd;
  logic [XLEN-1:0] buf_data;
  logic            drain;
  logic            pw;
  logic            bw;
  logic            same_rd;
  logic            buf_wins;
  logic            stall;
  wrSel_e          sel;

  ll_result_buf #(.XLEN(XLEN)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.ll_valid_i),
    .in_rd    (bus.ll_rd_i),
    .in_data  (bus.ll_data_i),
    .drain    (drain),
    .ready    (buf_ready),
    .full     (buf_full),
    .rd       (buf_rd),
    .data     (buf_data)
  );

  // Writes are suppressed while reset is held.
  assign pw      = rst_n & bus.wb_valid_i & (bus.wb_rd_i != 5'd0);
  assign bw      = buf_full & (buf_rd != 5'd0);
  assign same_rd = (bus.wb_rd_i == buf_rd);

  always_comb begin
    sel   = WR_SEL_NONE;
    stall = 1'b0;
    drain = buf_full & (buf_rd == 5'd0);
    if (pw && bw) begin
      if (same_rd) begin
        sel   = WR_SEL_WB;
        drain = 1'b1;
      end else if (buf_wins) begin
        sel   = WR_SEL_LL;
        drain = 1'b1;
        stall = 1'b1;
      end else begin
        sel   = WR_SEL_WB;
      end
    end else if (pw) begin
      sel = WR_SEL_WB;
    end else if (bw) begin
      sel   = WR_SEL_LL;
      drain = 1'b1;
    end
  end

`ifdef RF_ARB_AGING_EN
  localparam logic [3:0] AGE_LIM = 4'(AGE_MAX);
  logic [3:0] age_q;
  logic       lose;

  assign lose     = pw & bw & ~same_rd & (sel == WR_SEL_WB);
  assign buf_wins = (age_q >= AGE_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q <= '0;
    end else if (drain) begin
      age_q <= '0;
    end else if (lose && age_q != AGE_LIM) begin
      age_q <= age_q + 4'd1;
    end
  end
`else
  assign buf_wins = 1'b1;
`endif

  always_comb begin
    bus.rf_we_o    = 1'b0;
    bus.rf_waddr_o = '0;
    bus.rf_wdata_o = '0;
    case (sel)
      WR_SEL_WB: begin
        bus.rf_we_o    = 1'b1;
        bus.rf_waddr_o = bus.wb_rd_i;
        bus.rf_wdata_o = bus.wb_data_i;
      end
      WR_SEL_LL: begin
        bus.rf_we_o    = 1'b1;
        bus.rf_waddr_o = buf_rd;
        bus.rf_wdata_o = buf_data;
      end
      default: ;
    endcase
  end

  assign bus.wb_stall_o      = stall;
  assign bus.ll_ready_o      = buf_ready;
  assign bus.ll_pending_o    = buf_full;
  assign bus.ll_pending_rd_o = buf_rd;

endmodule
